// File: rtl/wb_sram_responder.sv
// Wishbone classic-cycle responder in front of a word-addressed single-port memory.
// Programmable wait states, byte-lane writes, abort while waiting, out-of-range detection.
// Optional macro WB_SRAM_RESPONDER_ERR_EN: out-of-range accesses terminate with err instead of ack.
module wb_sram_responder #(
  parameter int unsigned              ADDR_WIDTH  = 32,
  parameter int unsigned              DATA_WIDTH  = 32,
  parameter int unsigned              DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR   = '0,
  parameter int unsigned              WAIT_STATES = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wb_cyc,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_we,
  input  logic [ADDR_WIDTH-1:0]   i_wb_adr,
  input  logic [DATA_WIDTH-1:0]   i_wb_dat_w,
  input  logic [DATA_WIDTH/8-1:0] i_wb_sel,
  output logic [DATA_WIDTH-1:0]   o_wb_dat_r,
  output logic                    o_wb_ack,
  output logic                    o_wb_err
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q, hit_q, ack_q;
  logic [IdxW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0]   wdat_q, dat_r_q;
  logic [NumBytes-1:0]     sel_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

  logic                    req, live_hit, go_resp;
  logic [ADDR_WIDTH-1:0]   rel_adr, word_adr;
  logic [IdxW-1:0]         live_idx;
  logic                    cur_we, cur_hit;
  logic [IdxW-1:0]         cur_idx;
  logic [DATA_WIDTH-1:0]   cur_dat;
  logic [NumBytes-1:0]     cur_sel;

  assign req      = i_wb_cyc & i_wb_stb;
  assign rel_adr  = i_wb_adr - BASE_ADDR;
  assign word_adr = rel_adr >> OffW;
  assign live_hit = (i_wb_adr >= BASE_ADDR) && (word_adr < ADDR_WIDTH'(DEPTH_WORDS));
  assign live_idx = word_adr[IdxW-1:0];

  // Select the transfer attributes used on the edge that enters RESP; with zero wait
  // states that edge is the request edge itself, so the live bus values apply.
  always_comb begin
    cur_we  = we_q;
    cur_hit = hit_q;
    cur_idx = idx_q;
    cur_dat = wdat_q;
    cur_sel = sel_q;
    go_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        cur_we  = i_wb_we;
        cur_hit = live_hit;
        cur_idx = live_idx;
        cur_dat = i_wb_dat_w;
        cur_sel = i_wb_sel;
        go_resp = req && (WAIT_STATES == 0);
      end
      StWait:  go_resp = i_wb_cyc && (cnt_q == 4'd0);
      default: go_resp = 1'b0;
    endcase
  end

  // Control FSM with registered ack/err and read data.
`ifdef WB_SRAM_RESPONDER_ERR_EN
  logic err_q;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      dat_r_q <= '0;
      ack_q   <= 1'b0;
`ifdef WB_SRAM_RESPONDER_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef WB_SRAM_RESPONDER_ERR_EN
      err_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (req) begin
            we_q   <= i_wb_we;
            hit_q  <= live_hit;
            idx_q  <= live_idx;
            wdat_q <= i_wb_dat_w;
            sel_q  <= i_wb_sel;
            if (WAIT_STATES == 0) begin
              state_q <= StResp;
            end else begin
              cnt_q   <= 4'(WAIT_STATES - 1);
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (!i_wb_cyc) begin
            state_q <= StIdle;  // master abandoned the cycle: no write, no termination
          end else if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (go_resp) begin
`ifdef WB_SRAM_RESPONDER_ERR_EN
        ack_q <= cur_hit;
        err_q <= !cur_hit;
        if (!cur_we && cur_hit) dat_r_q <= mem_q[cur_idx];
`else
        ack_q <= 1'b1;
        if (!cur_we) dat_r_q <= cur_hit ? mem_q[cur_idx] : '0;
`endif
      end
    end
  end

  // Byte-enabled memory write; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && go_resp && cur_we && cur_hit) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (cur_sel[b]) mem_q[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

  assign o_wb_dat_r = dat_r_q;
  assign o_wb_ack   = ack_q;
`ifdef WB_SRAM_RESPONDER_ERR_EN
  assign o_wb_err   = err_q;
`else
  assign o_wb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sram_responder.sv
// Bench for wb_sram_responder: two instances (0 and 3 wait states, different bases)
// checked against a word-array model of the memory and the read-data register.
module tb_wb_sram_responder;

  localparam int unsigned Depth = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [31:0] adr [2];
  logic [31:0] dw  [2];
  logic [31:0] dr  [2];
  logic [3:0]  sel [2];
  logic        ack [2];
  logic        err [2];

  logic [31:0] mem_m [2][Depth];
  logic [31:0] rd_m  [2];
  int          n_pass = 0;
  int          n_chk  = 0;

  always #5 clk = ~clk;

  wb_sram_responder #(.WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
    .i_wb_adr(adr[0]), .i_wb_dat_w(dw[0]), .i_wb_sel(sel[0]), .o_wb_dat_r(dr[0]),
    .o_wb_ack(ack[0]), .o_wb_err(err[0])
  );

  wb_sram_responder #(.WAIT_STATES(3), .BASE_ADDR(32'h0000_1000)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
    .i_wb_adr(adr[1]), .i_wb_dat_w(dw[1]), .i_wb_sel(sel[1]), .o_wb_dat_r(dr[1]),
    .o_wb_ack(ack[1]), .o_wb_err(err[1])
  );

  function automatic logic [31:0] base_of(int k);
    return (k == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic bit in_range(int k, logic [31:0] a);
    return (a >= base_of(k)) && (((a - base_of(k)) >> 2) < Depth);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // One complete transfer; checks latency, termination kind, read data and pulse width.
  task automatic xfer(int k, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s, string tag);
    int          n;
    bit          got, hit, exp_ack, exp_err;
    int          idx;
    logic [31:0] word;
    hit = in_range(k, a);
    idx = int'((a - base_of(k)) >> 2);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dw[k] = d; sel[k] = s;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      if (ack[k] || err[k]) got = 1'b1;
      else n++;
    end
`ifdef WB_SRAM_RESPONDER_ERR_EN
    exp_ack = hit; exp_err = !hit;
`else
    exp_ack = 1'b1; exp_err = 1'b0;
`endif
    if (w && hit) begin
      word = mem_m[k][idx];
      for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
      mem_m[k][idx] = word;
    end
    if (!w) begin
      if (hit) rd_m[k] = mem_m[k][idx];
`ifndef WB_SRAM_RESPONDER_ERR_EN
      else rd_m[k] = 32'h0;
`endif
    end
    chk({tag, " latency"}, 32'(n), 32'(ws_of(k)));
    chk({tag, " ack"}, {31'b0, ack[k]}, {31'b0, exp_ack});
    chk({tag, " err"}, {31'b0, err[k]}, {31'b0, exp_err});
    chk({tag, " dat_r"}, dr[k], rd_m[k]);
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(posedge clk); #1;
    chk({tag, " pulse width"}, {30'b0, ack[k], err[k]}, 32'h0);
  endtask

  initial begin
    int          i;
    logic [31:0] a, d;
    bit          any;
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = 0; dw[k] = 0; sel[k] = 0; rd_m[k] = 0;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("reset ack", {31'b0, ack[k]}, 32'h0);
      chk("reset err", {31'b0, err[k]}, 32'h0);
      chk("reset dat_r", dr[k], 32'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 2; k++) begin
      // Basic write then read.
      xfer(k, 1, base_of(k), 32'hA5A5_0001, 4'hF, "wr0");
      xfer(k, 0, base_of(k), 32'h0, 4'hF, "rd0");
      chk("rd0 const", dr[k], 32'hA5A5_0001);
      // Byte lanes.
      xfer(k, 1, base_of(k) + 32'h10, 32'hFFFF_FFFF, 4'hF, "lane fill");
      xfer(k, 1, base_of(k) + 32'h10, 32'h1234_5678, 4'b0101, "lane part");
      xfer(k, 0, base_of(k) + 32'h10, 32'h0, 4'hF, "lane rd");
      chk("lane const", dr[k], 32'hFF34_FF78);
      // Preload 64 words, then stream them back.
      for (i = 0; i < 64; i++) xfer(k, 1, base_of(k) + 32'(i * 4), 32'(i + 1), 4'hF, "preload");
      for (i = 0; i < 64; i++) xfer(k, 0, base_of(k) + 32'(i * 4), 32'h0, 4'hF, "stream rd");
      // Randomised mix; low address bits are ignored by the decode.
      for (i = 0; i < 60; i++) begin
        a = base_of(k) + 32'($urandom_range(63, 0) * 4) + 32'($urandom_range(3, 0));
        xfer(k, bit'($urandom_range(1, 0)), a, $urandom, 4'($urandom_range(15, 0)), "rand");
      end
      // Boundaries: last word in range, just past the end, below the base.
      xfer(k, 1, base_of(k) + 32'((Depth - 1) * 4), 32'hC0DE_0001, 4'hF, "last wr");
      xfer(k, 0, base_of(k) + 32'((Depth - 1) * 4), 32'h0, 4'hF, "last rd");
      xfer(k, 0, base_of(k) + 32'h4, 32'h0, 4'hF, "pre oor rd");
      xfer(k, 0, base_of(k) + 32'(Depth * 4), 32'h0, 4'hF, "oor rd");
      xfer(k, 1, base_of(k) + 32'(Depth * 4), 32'hBAD0_BAD0, 4'hF, "oor wr");
      xfer(k, 0, base_of(k), 32'h0, 4'hF, "alias rd");
      if (k == 1) xfer(k, 0, base_of(k) - 32'h4, 32'h0, 4'hF, "below base rd");
    end

    // Abort during wait states: the write must not land and nothing terminates.
    xfer(1, 1, 32'h1020, 32'h0000_0000, 4'hF, "abort pre");
    cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h1020; dw[1] = 32'hDEAD_BEEF; sel[1] = 4'hF;
    @(posedge clk); #1;
    cyc[1] = 0; stb[1] = 0;
    any = 1'b0;
    for (i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      any = any | ack[1] | err[1];
    end
    chk("abort no term", {31'b0, any}, 32'h0);
    xfer(1, 0, 32'h1020, 32'h0, 4'hF, "abort rd");
    chk("abort const", dr[1], 32'h0);

    // Asynchronous reset while a write waits: outputs clear without a clock edge.
    xfer(1, 1, 32'h1008, 32'h0BAD_F00D, 4'hF, "rst pre wr");
    xfer(1, 0, 32'h1008, 32'h0, 4'hF, "rst pre rd");
    cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h1004; dw[1] = 32'h1111_2222; sel[1] = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst ack", {31'b0, ack[1]}, 32'h0);
    chk("rst err", {31'b0, err[1]}, 32'h0);
    chk("rst dat_r", dr[1], 32'h0);
    chk("rst dat_r other", dr[0], 32'h0);
    rd_m[0] = 32'h0; rd_m[1] = 32'h0;
    cyc[1] = 0; stb[1] = 0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 0, 32'h1004, 32'h0, 4'hF, "lost wr rd");
    xfer(1, 1, 32'h1004, 32'h5555_AAAA, 4'hF, "post rst wr");
    xfer(1, 0, 32'h1004, 32'h0, 4'hF, "post rst rd");
    chk("post rst const", dr[1], 32'h5555_AAAA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "timeout");
  end

endmodule
